slave_msg_collector: RTL and testbench
======================================

// Module: slave_msg_collector
// PURPOSE
//  Read-side counterpart of the per-address register/slave blocks. Scans have_msg_bus, grants one
//  slave round-robin, pops its message via rdreq_bus, and frames it as a byte stream to the host
//  link: SYNC, ADDR, LEN, payload, CSUM. Sits between the slave blocks and the host TX serializer.
// PARAMETERS
//  N_SLAVES  9     number of slave channels; address byte = channel index 0..N_SLAVES-1
//  SYNC_BYTE 8'h55 first byte of every packet
// PORTS
//  clk             in  1           system clock
//  n_rst           in  1           asynchronous active-low reset
//  have_msg_bus    in  N_SLAVES    bit i: slave i FIFO not empty
//  slave_data_bus  in  8*N_SLAVES  byte i at [8*i+7:8*i]; show-ahead FIFO head of slave i
//  len_bus         in  8*N_SLAVES  byte i: pending message length of slave i, 0..255
//  rdreq_bus       out N_SLAVES    one-cycle pop strobe to the granted slave
//  tx_data         out 8           framed byte to host link
//  tx_valid        out 1           tx_data valid; byte transfers when tx_valid & tx_ready
//  tx_ready        in  1           host link accepts byte
//  busy            out 1           high from grant until CSUM accepted
//  err_underflow   out 1           sticky; slave emptied before LEN bytes were read
//  clr_err         in  1           synchronous clear of err_underflow
// BEHAVIOUR
//  Reset values: rdreq_bus=0, tx_data=0, tx_valid=0, busy=0, err_underflow=0, state=IDLE, last_grant=N_SLAVES-1.
//  Reset is asynchronous and may hit mid-packet: the partial packet is abandoned, the FIFO is not
//  rewound, and the scan restarts at channel 0.
//  Output register: tx_data/tx_valid are registered. A new byte loads only when !tx_valid | tx_ready.
//  tx_data is held stable while tx_valid & !tx_ready. tx_valid drops when a byte is accepted and no new byte loads.
//  FSM: IDLE -> HDR_SYNC -> HDR_ADDR -> HDR_LEN -> DATA -> CSUM -> IDLE.
//   IDLE: one arbitration cycle. Search last_grant+1 .. wrapping mod N_SLAVES for the first i
//     with have_msg_bus[i] & len_bus[i]!=0. On a hit: latch sel=i and len_q=len_bus[i], set busy,
//     set last_grant=i, go HDR_SYNC. Channels with len=0 are skipped (no rdreq, no packet).
//   HDR_SYNC/HDR_ADDR/HDR_LEN: on each load slot, load SYNC_BYTE, {sel} zero-extended to 8 bits,
//     and len_q in turn.
//   DATA: on each load slot, load slave_data_bus[sel] and pulse rdreq_bus[sel] in that same cycle,
//     then decrement the remaining count. Show-ahead timing: the next byte is valid on the following
//     cycle, so back-to-back pops are allowed (1 byte/clk with tx_ready=1). After len_q bytes, go CSUM.
//   Underflow: if have_msg_bus[sel]=0 at a DATA load slot, load 8'h00 with no rdreq, set
//     err_underflow, and continue. The packet length is always exactly len_q payload bytes.
//   CSUM: load the XOR of the ADDR byte, the LEN byte and all payload bytes (SYNC excluded; pad
//     bytes included). When the CSUM byte is accepted, clear busy and go IDLE.
//  rdreq_bus is one-hot or zero, never asserted outside DATA, and at most len_q pulses per packet.
//  have_msg/len changes on non-granted channels during a packet have no effect until IDLE.
//  clr_err and an underflow event in the same cycle: err_underflow=1 (set wins).
//  Minimum packet gap: 1 IDLE cycle. Latency from have_msg rise in IDLE to tx_valid: 2 clk.
// TESTING
//  T1 ch3, len=2, data A1,B2, tx_ready=1 -> tx stream 55 03 02 A1 B2 12; rdreq_bus[3] pulses exactly twice, back-to-back.
//  T2 ch0 and ch5 pending and refilled after each read -> packet order 0,5,0,5; after reset the first grant is ch0.
//  T3 T1 with tx_ready toggling 1010.. -> identical byte stream; tx_data stable while stalled; 2 rdreq total.
//  T4 ch2 have_msg=1, len=0, plus ch4 len=1 data 7E -> only 55 04 01 7E 7B is emitted; no rdreq[2].
//  T5 ch1 len=3, FIFO holds 1 byte (C3) -> 55 01 03 C3 00 00 C1; err_underflow=1; clr_err pulse -> 0.
//  T6 n_rst asserted after 1st payload byte of a len=4 packet -> all outputs return to reset values at once; the next packet is a complete frame.

Source files
------------

// File: rtl/slave_msg_collector.sv
// Round-robin collector that pops one slave message at a time and frames it for the host
// link as SYNC, ADDR, LEN, payload, CSUM.
//
// Ports:
//   clk, n_rst           system clock, asynchronous active-low reset
//   have_msg_bus         per-slave FIFO-not-empty flags
//   slave_data_bus       per-slave show-ahead FIFO head bytes, byte i at [8*i+7:8*i]
//   len_bus              per-slave pending message length bytes
//   rdreq_bus            one-cycle pop strobe to the granted slave
//   tx_data, tx_valid    registered byte stream to the host link
//   tx_ready             host link accepts the current byte
//   busy                 high from grant until the CSUM byte is accepted
//   err_underflow        sticky flag: granted slave ran dry mid-message
//   clr_err              synchronous clear of err_underflow

module slave_msg_collector #(
    parameter int         N_SLAVES  = 9,
    parameter logic [7:0] SYNC_BYTE = 8'h55
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [N_SLAVES-1:0]   have_msg_bus,
    input  logic [8*N_SLAVES-1:0] slave_data_bus,
    input  logic [8*N_SLAVES-1:0] len_bus,
    output logic [N_SLAVES-1:0]   rdreq_bus,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  err_underflow,
    input  logic                  clr_err
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR_SYNC,
        HDR_ADDR,
        HDR_LEN,
        DATA,
        CSUM,
        CSUM_WAIT
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] last_grant_q;
    logic [7:0]       len_q;
    logic [7:0]       cnt_q;
    logic [7:0]       csum_q;

    logic [7:0]       len_arr [N_SLAVES];
    logic [7:0]       dat_arr [N_SLAVES];

    logic             hit;
    logic [IDX_W-1:0] pick;
    logic             load_ok;
    logic             data_ok;
    logic [7:0]       sel_byte;
    logic [7:0]       pay_byte;

    for (genvar g = 0; g < N_SLAVES; g++) begin : g_unpack
        assign len_arr[g] = len_bus[8*g +: 8];
        assign dat_arr[g] = slave_data_bus[8*g +: 8];
    end

    // A new byte may enter the output register when it is empty or draining.
    assign load_ok  = !tx_valid | tx_ready;
    assign sel_byte = 8'(sel_q);
    assign data_ok  = have_msg_bus[sel_q];
    assign pay_byte = data_ok ? dat_arr[sel_q] : 8'h00;

    // Round-robin scan starting just after the last grant.
    // Zero-length messages are not eligible.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int k = 1; k <= N_SLAVES; k++) begin
            int c;
            c = (int'(last_grant_q) + k) % N_SLAVES;
            if (!hit && have_msg_bus[IDX_W'(c)] &&
                len_arr[IDX_W'(c)] != 8'd0) begin
                hit  = 1'b1;
                pick = IDX_W'(c);
            end
        end
    end

    // The pop must coincide with the cycle the head byte is captured,
    // so the strobe is decoded from the current state, not registered.
    always_comb begin
        rdreq_bus = '0;
        if (state_q == DATA && load_ok && data_ok) begin
            rdreq_bus[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            last_grant_q  <= IDX_W'(N_SLAVES - 1);
            len_q         <= 8'h00;
            cnt_q         <= 8'h00;
            csum_q        <= 8'h00;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            busy          <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                err_underflow <= 1'b0;
            end
            // Accepted byte leaves; a load below re-asserts valid.
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        sel_q        <= pick;
                        len_q        <= len_arr[pick];
                        last_grant_q <= pick;
                        busy         <= 1'b1;
                        state_q      <= HDR_SYNC;
                    end
                end
                HDR_SYNC: begin
                    if (load_ok) begin
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        state_q  <= HDR_ADDR;
                    end
                end
                HDR_ADDR: begin
                    if (load_ok) begin
                        tx_data  <= sel_byte;
                        tx_valid <= 1'b1;
                        csum_q   <= sel_byte;
                        state_q  <= HDR_LEN;
                    end
                end
                HDR_LEN: begin
                    if (load_ok) begin
                        tx_data  <= len_q;
                        tx_valid <= 1'b1;
                        csum_q   <= csum_q ^ len_q;
                        cnt_q    <= len_q;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (load_ok) begin
                        tx_data  <= pay_byte;
                        tx_valid <= 1'b1;
                        csum_q   <= csum_q ^ pay_byte;
                        cnt_q    <= cnt_q - 8'd1;
                        // Pad with zero and keep going so the frame
                        // length always matches the advertised LEN.
                        if (!data_ok) begin
                            err_underflow <= 1'b1;
                        end
                        if (cnt_q == 8'd1) begin
                            state_q <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (load_ok) begin
                        tx_data  <= csum_q;
                        tx_valid <= 1'b1;
                        state_q  <= CSUM_WAIT;
                    end
                end
                CSUM_WAIT: begin
                    if (tx_ready) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_msg_collector.sv
// Bench for slave_msg_collector: show-ahead FIFO slave models, a packet-level
// reference model of arbitration and framing, directed and randomized scenarios.

module tb_slave_msg_collector;

    localparam int N = 9;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [N-1:0]   have_msg_bus;
    logic [8*N-1:0] slave_data_bus;
    logic [8*N-1:0] len_bus;
    logic [N-1:0]   rdreq_bus;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic           err_underflow;
    logic           clr_err;

    slave_msg_collector #(
        .N_SLAVES (N),
        .SYNC_BYTE(8'h55)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .have_msg_bus  (have_msg_bus),
        .slave_data_bus(slave_data_bus),
        .len_bus       (len_bus),
        .rdreq_bus     (rdreq_bus),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .err_underflow (err_underflow),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo [N][$];
    logic [7:0] lens [N];
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    int         exp_pops [N];
    int         pops [N];
    int         pop_cyc [$];
    bit         exp_uf;
    int         model_last;
    int         first_valid;
    int         stab_bad;
    int         oh_bad;
    int         errors = 0;
    int         checks = 0;

    function automatic void drive_bus();
        for (int i = 0; i < N; i++) begin
            have_msg_bus[i] = fifo[i].size() != 0;
            slave_data_bus[8*i +: 8] = (fifo[i].size() != 0) ? fifo[i][0] : 8'h00;
            len_bus[8*i +: 8] = lens[i];
        end
    endfunction

    // Packet-level reference: whole frames from the FIFO contents and rules.
    function automatic void model();
        logic [7:0] m [N][$];
        int         hit;
        int         c;
        logic [7:0] cs;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            m[i] = fifo[i];
            exp_pops[i] = 0;
        end
        exp_q.delete();
        exp_uf = 1'b0;
        while (1) begin
            hit = -1;
            for (int k = 1; k <= N; k++) begin
                c = (model_last + k) % N;
                if (hit < 0 && m[c].size() > 0 && lens[c] != 8'd0) hit = c;
            end
            if (hit < 0) break;
            model_last = hit;
            cs = 8'(hit) ^ lens[hit];
            exp_q.push_back(8'h55);
            exp_q.push_back(8'(hit));
            exp_q.push_back(lens[hit]);
            for (int j = 0; j < int'(lens[hit]); j++) begin
                if (m[hit].size() > 0) begin
                    b = m[hit].pop_front();
                    exp_pops[hit]++;
                end else begin
                    b = 8'h00;
                    exp_uf = 1'b1;
                end
                cs = cs ^ b;
                exp_q.push_back(b);
            end
            exp_q.push_back(cs);
        end
    endfunction

    function automatic int diff_at();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] gq(input int i);
        return (i < got.size()) ? got[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] eq(input int i);
        return (i < exp_q.size()) ? exp_q[i] : 8'hxx;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            fifo[i].delete();
            lens[i] = 8'd0;
        end
        drive_bus();
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_last = N - 1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    // mode 0: ready=1, 1: ready toggles 1010.., 2: random ready
    task automatic run(input int mode, input int budget, input int target, input int tail);
        int         cyc;
        int         idle;
        logic [N-1:0] pend;
        logic [7:0] held;
        bit         stalled;
        cyc = 0;
        idle = 0;
        stalled = 1'b0;
        held = 8'h00;
        got.delete();
        pop_cyc.delete();
        for (int i = 0; i < N; i++) pops[i] = 0;
        first_valid = -1;
        stab_bad = 0;
        oh_bad = 0;
        while (cyc < budget && (got.size() < target || idle < tail)) begin
            if (got.size() >= target) tx_ready = 1'b1;
            else if (mode == 0) tx_ready = 1'b1;
            else if (mode == 1) tx_ready = (cyc % 2) == 0;
            else tx_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (stalled && (tx_data !== held || tx_valid !== 1'b1)) stab_bad++;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            stalled = tx_valid && !tx_ready;
            held = tx_data;
            if ($countones(rdreq_bus) > 1) oh_bad++;
            if (rdreq_bus != '0 && !busy) oh_bad++;
            pend = rdreq_bus;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    pops[i]++;
                    pop_cyc.push_back(cyc);
                    if (fifo[i].size() > 0) void'(fifo[i].pop_front());
                end
            end
            drive_bus();
            cyc++;
            if (got.size() >= target) idle++;
        end
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL run_timeout: got %0d bytes, required %0d", got.size(), target);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        tx_ready = 1'b0;
        clr_err = 1'b0;
        clear_all();
        #2;
        n_rst = 1'b0;
        #2;
        checks++;
        if (rdreq_bus !== '0) begin
            errors++;
            $display("FAIL reset_rdreq: got %h, required 0", rdreq_bus);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_valid: got %b, required 0", tx_valid);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data: got %h, required 00", tx_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b, required 0", err_underflow);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_last = N - 1;
    endtask

    task automatic test_basic(input int mode, input string nm);
        logic [7:0] lit [6] = '{8'h55, 8'h03, 8'h02, 8'hA1, 8'hB2, 8'h12};
        int bad;
        int d;
        clear_all();
        fifo[3] = '{8'hA1, 8'hB2};
        lens[3] = 8'd2;
        drive_bus();
        model();
        run(mode, 400, exp_q.size(), 4);
        d = diff_at();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL %s_model_stream: byte %0d got %h, required %h", nm, d, gq(d), eq(d));
        end
        bad = (got.size() != 6) ? 1 : 0;
        for (int i = 0; i < 6 && i < got.size(); i++) if (got[i] !== lit[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_literal_stream: got %0d bytes with %0d bad, required 55 03 02 A1 B2 12",
                     nm, got.size(), bad);
        end
        checks++;
        if (pops[3] != 2 || pop_cyc.size() != 2) begin
            errors++;
            $display("FAIL %s_rdreq_count: got %0d/%0d, required 2", nm, pops[3], pop_cyc.size());
        end
        checks++;
        if (stab_bad != 0 || oh_bad != 0) begin
            errors++;
            $display("FAIL %s_hold_onehot: got %0d/%0d, required 0/0", nm, stab_bad, oh_bad);
        end
        checks++;
        if (busy !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_flags: got busy=%b err=%b, required 0 0", nm, busy, err_underflow);
        end
        if (mode == 0) begin
            checks++;
            if (first_valid != 2) begin
                errors++;
                $display("FAIL latency: got %0d, required 2", first_valid);
            end
            checks++;
            if (pop_cyc.size() != 2 || pop_cyc[1] - pop_cyc[0] != 1) begin
                errors++;
                $display("FAIL back_to_back_pop: got %0d pops, required consecutive", pop_cyc.size());
            end
        end
    endtask

    task automatic test_round_robin();
        int d;
        logic [7:0] a [4];
        pulse_reset();
        clear_all();
        fifo[0] = '{8'h10, 8'h11, 8'h12, 8'h13};
        fifo[5] = '{8'h50, 8'h51, 8'h52, 8'h53};
        lens[0] = 8'd2;
        lens[5] = 8'd2;
        drive_bus();
        model();
        run(0, 400, exp_q.size(), 4);
        d = diff_at();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rr_stream: byte %0d got %h, required %h", d, gq(d), eq(d));
        end
        for (int p = 0; p < 4; p++) a[p] = gq(1 + 6 * p);
        checks++;
        if (a[0] !== 8'h00 || a[1] !== 8'h05 || a[2] !== 8'h00 || a[3] !== 8'h05) begin
            errors++;
            $display("FAIL rr_order: got %h %h %h %h, required 00 05 00 05", a[0], a[1], a[2], a[3]);
        end
        checks++;
        if (pops[0] != 4 || pops[5] != 4) begin
            errors++;
            $display("FAIL rr_pops: got %0d/%0d, required 4/4", pops[0], pops[5]);
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] lit [5] = '{8'h55, 8'h04, 8'h01, 8'h7E, 8'h7B};
        int bad;
        clear_all();
        fifo[2] = '{8'h99};
        fifo[4] = '{8'h7E};
        lens[4] = 8'd1;
        drive_bus();
        model();
        run(0, 400, exp_q.size(), 6);
        bad = (got.size() != 5) ? 1 : 0;
        for (int i = 0; i < 5 && i < got.size(); i++) if (got[i] !== lit[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_len_stream: got %0d bytes with %0d bad, required 55 04 01 7E 7B",
                     got.size(), bad);
        end
        checks++;
        if (pops[2] != 0 || pops[4] != 1) begin
            errors++;
            $display("FAIL zero_len_pops: got ch2=%0d ch4=%0d, required 0 1", pops[2], pops[4]);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] lit [7] = '{8'h55, 8'h01, 8'h03, 8'hC3, 8'h00, 8'h00, 8'hC1};
        int bad;
        clear_all();
        fifo[1] = '{8'hC3};
        lens[1] = 8'd3;
        drive_bus();
        model();
        run(0, 400, exp_q.size(), 4);
        bad = (got.size() != 7) ? 1 : 0;
        for (int i = 0; i < 7 && i < got.size(); i++) if (got[i] !== lit[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL underflow_stream: got %0d bytes with %0d bad, required 55 01 03 C3 00 00 C1",
                     got.size(), bad);
        end
        checks++;
        if (err_underflow !== 1'b1 || pops[1] != 1) begin
            errors++;
            $display("FAIL underflow_flag: got err=%b pops=%0d, required 1 1", err_underflow, pops[1]);
        end
        pulse_clr();
        @(negedge clk);
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: got %b, required 0", err_underflow);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int d;
        logic [7:0] pre [4];
        pulse_reset();
        clear_all();
        for (int i = 0; i < 6; i++) fifo[6].push_back(8'($urandom));
        lens[6] = 8'd4;
        drive_bus();
        model();
        for (int i = 0; i < 4; i++) pre[i] = exp_q[i];
        run(0, 400, 4, 0);
        checks++;
        if (got.size() != 4 || gq(0) !== pre[0] || gq(1) !== pre[1] ||
            gq(2) !== pre[2] || gq(3) !== pre[3]) begin
            errors++;
            $display("FAIL mid_prefix: got %h %h %h %h, required %h %h %h %h",
                     gq(0), gq(1), gq(2), gq(3), pre[0], pre[1], pre[2], pre[3]);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (rdreq_bus !== '0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdreq=%h v=%b d=%h busy=%b, required 0 0 00 0",
                     rdreq_bus, tx_valid, tx_data, busy);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_last = N - 1;
        model();
        run(0, 400, exp_q.size(), 4);
        d = diff_at();
        checks++;
        if (d != -1 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL mid_next_frame: byte %0d got %h, required %h (len %0d of %0d)",
                     d, gq(d), eq(d), got.size(), exp_q.size());
        end
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_err: got %b, required 0", err_underflow);
        end
    endtask

    task automatic test_random();
        int d;
        int bad;
        int nch;
        int ch;
        int sz;
        for (int r = 0; r < 8; r++) begin
            clear_all();
            pulse_clr();
            nch = $urandom_range(1, 5);
            for (int c = 0; c < nch; c++) begin
                ch = $urandom_range(0, N - 1);
                sz = $urandom_range(0, 5);
                for (int b = 0; b < sz; b++) fifo[ch].push_back(8'($urandom));
                lens[ch] = 8'($urandom_range(0, 5));
            end
            drive_bus();
            model();
            run(2, 3000, exp_q.size(), 4);
            d = diff_at();
            checks++;
            if (d != -1) begin
                errors++;
                $display("FAIL rand%0d_stream: byte %0d got %h, required %h", r, d, gq(d), eq(d));
            end
            bad = 0;
            for (int i = 0; i < N; i++) if (pops[i] != exp_pops[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand%0d_pops: %0d channels differ from model", r, bad);
            end
            checks++;
            if (err_underflow !== exp_uf) begin
                errors++;
                $display("FAIL rand%0d_err: got %b, required %b", r, err_underflow, exp_uf);
            end
            checks++;
            if (stab_bad != 0 || oh_bad != 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_protocol: got hold=%0d onehot=%0d busy=%b, required 0 0 0",
                         r, stab_bad, oh_bad, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(0, "t1");
        test_round_robin();
        test_basic(1, "t3");
        test_zero_len();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
